// File: rtl/cfg_bus_arbiter_pkg.sv
// Shared types and constants for the config-bus arbiter.
package cfg_bus_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [15:0] cfg_addr_t;
    typedef logic [1:0]  arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_WRITE = 2'd1;
    localparam arb_state_t ST_READ  = 2'd2;

    localparam word_t CFG_ARB_ERR_RDATA = 32'hBADC_0FFE;

endpackage

// File: rtl/cfg_bus_arbiter_rr.sv
// Combinational cyclic priority pick: first requester at or after ptr, wrapping.
module cfg_bus_arbiter_rr #(
    parameter int NumReq = 2,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   winner,
    output logic              valid
);

    int j;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        j      = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NumReq) j = j - NumReq;
            if (req[j]) begin
                winner = j[IdxW-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Round-robin arbiter sharing one config slave port among NumReq masters,
// one transaction at a time, with an optional stall timeout.
module cfg_bus_arbiter
    import cfg_bus_arbiter_pkg::*;
#(
    parameter int    NumReq        = 2,
    parameter int    TimeoutCycles = 255,
    parameter word_t ErrRdata      = CFG_ARB_ERR_RDATA
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumReq-1:0]            mst_req_i,
    input  logic [NumReq-1:0]            mst_wen_i,
    input  cfg_addr_t [NumReq-1:0]       mst_addr_i,
    input  word_t [NumReq-1:0]           mst_wdata_i,
    output logic [NumReq-1:0]            mst_gnt_o,
    output logic [NumReq-1:0]            mst_rvalid_o,
    output word_t                        mst_rdata_o,
    output logic                         slv_req_o,
    input  logic                         slv_gnt_i,
    output logic                         slv_wen_o,
    output cfg_addr_t                    slv_addr_o,
    output word_t                        slv_wdata_o,
    input  word_t                        slv_rdata_i,
    input  logic                         slv_rvalid_i,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumReq - 1);
    localparam logic [CntW-1:0] ExpireCnt = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    arb_state_t      state;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] win_idx;
    cfg_addr_t       lat_addr;
    word_t           lat_wdata;
    logic            lat_wen;
    logic [CntW-1:0] cnt;

    logic [IdxW-1:0] pick;
    logic            pick_valid;
    logic            active;
    logic            live;
    logic            rsp;
    logic            expire;
    logic            done;

    cfg_bus_arbiter_rr #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr (
        .req    (mst_req_i),
        .ptr    (rr_ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    // The live winner request gates everything: dropping it aborts the transaction.
    assign active = (state == ST_WRITE) || (state == ST_READ);
    assign live   = active && mst_req_i[win_idx];
    assign rsp    = ((state == ST_WRITE) && slv_gnt_i) || ((state == ST_READ) && slv_rvalid_i);
    assign expire = (TimeoutCycles > 0) && live && !rsp && (cnt == ExpireCnt);
    assign done   = live && (rsp || expire);

    assign slv_req_o   = live;
    assign slv_wen_o   = (state != ST_WRITE);
    assign slv_addr_o  = lat_addr;
    assign slv_wdata_o = lat_wdata;
    assign busy_o      = active;
    assign timeout_o   = expire;

    always_comb begin
        mst_gnt_o    = '0;
        mst_rvalid_o = '0;
        mst_rdata_o  = '0;
        if (done && state == ST_WRITE) begin
            mst_gnt_o[win_idx] = 1'b1;
        end
        if (done && state == ST_READ) begin
            mst_rvalid_o[win_idx] = 1'b1;
            mst_rdata_o           = rsp ? slv_rdata_i : ErrRdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            win_idx   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wen   <= 1'b1;
            cnt       <= '0;
        end else if (state == ST_IDLE) begin
            if (pick_valid) begin
                win_idx   <= pick;
                lat_addr  <= mst_addr_i[pick];
                lat_wdata <= mst_wdata_i[pick];
                lat_wen   <= mst_wen_i[pick];
                state     <= mst_wen_i[pick] ? ST_READ : ST_WRITE;
                cnt       <= '0;
            end
        end else if (!live || done) begin
            // Completion and abort both hand priority to the next master.
            state  <= ST_IDLE;
            rr_ptr <= (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Bench for cfg_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_cfg_bus_arbiter;
    import cfg_bus_arbiter_pkg::*;

    localparam int          NR  = 2;
    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hBADC_0FFE;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic [NR-1:0]       mst_req_i = '0;
    logic [NR-1:0]       mst_wen_i = '1;
    logic [NR-1:0][15:0] mst_addr_i = '0;
    logic [NR-1:0][31:0] mst_wdata_i = '0;
    logic [NR-1:0]       mst_gnt_o;
    logic [NR-1:0]       mst_rvalid_o;
    logic [31:0]         mst_rdata_o;
    logic                slv_req_o;
    logic                slv_gnt_i = 1'b0;
    logic                slv_wen_o;
    logic [15:0]         slv_addr_o;
    logic [31:0]         slv_wdata_o;
    logic [31:0]         slv_rdata_i = '0;
    logic                slv_rvalid_i = 1'b0;
    logic                busy_o;
    logic                timeout_o;

    int errors = 0;
    int checks = 0;

    cfg_bus_arbiter #(
        .NumReq        (NR),
        .TimeoutCycles (T),
        .ErrRdata      (ERR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .mst_req_i    (mst_req_i),
        .mst_wen_i    (mst_wen_i),
        .mst_addr_i   (mst_addr_i),
        .mst_wdata_i  (mst_wdata_i),
        .mst_gnt_o    (mst_gnt_o),
        .mst_rvalid_o (mst_rvalid_o),
        .mst_rdata_o  (mst_rdata_o),
        .slv_req_o    (slv_req_o),
        .slv_gnt_i    (slv_gnt_i),
        .slv_wen_o    (slv_wen_o),
        .slv_addr_o   (slv_addr_o),
        .slv_wdata_o  (slv_wdata_o),
        .slv_rdata_i  (slv_rdata_i),
        .slv_rvalid_i (slv_rvalid_i),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one open transaction (owner, kind, fields, age).
    logic        m_ok = 1'b0;
    logic        m_busy = 1'b0;
    int          m_owner = 0;
    logic        m_wen = 1'b1;
    logic [15:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    int          m_wait = 0;
    int          m_rr = 0;
    logic [NR-1:0] m_last_done = '0;

    logic          e_live, e_rsp, e_expire, e_done, e_has;
    int            e_pick;
    logic [NR-1:0] e_gnt, e_rvalid;
    logic [31:0]   e_rdata;

    always_comb begin
        e_live   = m_busy && mst_req_i[m_owner];
        e_rsp    = m_busy && (m_wen ? slv_rvalid_i : slv_gnt_i);
        e_expire = e_live && !e_rsp && (m_wait == T - 1);
        e_done   = e_live && (e_rsp || e_expire);
        e_gnt    = '0;
        e_rvalid = '0;
        e_rdata  = '0;
        if (e_done && m_wen) begin
            e_rvalid[m_owner] = 1'b1;
            e_rdata           = e_rsp ? slv_rdata_i : ERR;
        end
        if (e_done && !m_wen) e_gnt[m_owner] = 1'b1;
        e_has  = 1'b0;
        e_pick = 0;
        for (int k = 0; k < NR; k++) begin
            if (!e_has && mst_req_i[(m_rr + k) % NR]) begin
                e_has  = 1'b1;
                e_pick = (m_rr + k) % NR;
            end
        end
    end

    always @(posedge clk) begin
        m_ok        <= m_ok | rst_i;
        m_last_done <= e_gnt | e_rvalid;
        if (rst_i) begin
            m_busy      <= 1'b0;
            m_owner     <= 0;
            m_wen       <= 1'b1;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wait      <= 0;
            m_rr        <= 0;
            m_last_done <= '0;
        end else if (!m_busy) begin
            if (e_has) begin
                m_busy  <= 1'b1;
                m_owner <= e_pick;
                m_wen   <= mst_wen_i[e_pick];
                m_addr  <= mst_addr_i[e_pick];
                m_wdata <= mst_wdata_i[e_pick];
                m_wait  <= 0;
            end
        end else if (!e_live || e_done) begin
            m_busy <= 1'b0;
            m_rr   <= (m_owner + 1) % NR;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cmp_slv_req", 32'(slv_req_o), 32'(e_live));
            chk("cmp_busy", 32'(busy_o), 32'(m_busy));
            chk("cmp_gnt", 32'(mst_gnt_o), 32'(e_gnt));
            chk("cmp_rvalid", 32'(mst_rvalid_o), 32'(e_rvalid));
            chk("cmp_rdata", mst_rdata_o, e_rdata);
            chk("cmp_timeout", 32'(timeout_o), 32'(e_expire));
            chk("cmp_slv_addr", 32'(slv_addr_o), 32'(m_addr));
            chk("cmp_slv_wdata", slv_wdata_o, m_wdata);
            if (e_live) chk("cmp_slv_wen", 32'(slv_wen_o), 32'(m_wen));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        mst_req_i    = '0;
        slv_gnt_i    = 1'b0;
        slv_rvalid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Serves master 'who' (already requesting, arbiter idle); slave answers on cycle resp_at.
    task automatic serve(input int who, input int resp_at, input logic rd, input logic [31:0] data);
        logic [NR-1:0] onehot;
        onehot = '0;
        onehot[who] = 1'b1;
        @(negedge clk); #1;
        chk("idle_slv_req", 32'(slv_req_o), 32'd0);
        tick();
        for (int k = 1; k <= resp_at; k++) begin
            slv_gnt_i    = !rd && (k == resp_at);
            slv_rvalid_i = rd && (k == resp_at);
            slv_rdata_i  = data;
            @(negedge clk); #1;
            chk("slv_req", 32'(slv_req_o), 32'd1);
            chk("slv_wen", 32'(slv_wen_o), 32'(rd));
            chk("slv_addr", 32'(slv_addr_o), 32'(mst_addr_i[who]));
            if (k == resp_at) begin
                chk("gnt", 32'(mst_gnt_o), rd ? 32'd0 : 32'(onehot));
                chk("rvalid", 32'(mst_rvalid_o), rd ? 32'(onehot) : 32'd0);
                chk("rdata", mst_rdata_o, rd ? data : 32'd0);
                chk("timeout", 32'(timeout_o), 32'd0);
            end else begin
                chk("early_gnt", 32'(mst_gnt_o), 32'd0);
                chk("early_rvalid", 32'(mst_rvalid_o), 32'd0);
            end
            tick();
        end
        slv_gnt_i      = 1'b0;
        slv_rvalid_i   = 1'b0;
        mst_req_i[who] = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk); #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_slv_wen", 32'(slv_wen_o), 32'd1);
        chk("rst_slv_req", 32'(slv_req_o), 32'd0);
        chk("rst_gnt", 32'(mst_gnt_o), 32'd0);
        chk("rst_rdata", mst_rdata_o, 32'd0);
        chk("rst_slv_addr", 32'(slv_addr_o), 32'd0);
        tick();

        // Master 0 write, grant on the third write cycle.
        mst_req_i[0] = 1'b1; mst_wen_i[0] = 1'b0;
        mst_addr_i[0] = 16'h3004; mst_wdata_i[0] = 32'h1234;
        serve(0, 3, 1'b0, 32'h0);
        chk("model_rr_after_write", 32'(m_rr), 32'd1);

        // Simultaneous reads from reset: master 0 then master 1.
        do_reset();
        mst_wen_i = 2'b11;
        mst_addr_i[0] = 16'h0010; mst_addr_i[1] = 16'h0020;
        mst_req_i = 2'b11;
        serve(0, 2, 1'b1, 32'hA5A5);
        serve(1, 2, 1'b1, 32'hA5A5);

        // Master 1 read, silent slave: forced completion on the 4th request cycle.
        mst_req_i[1] = 1'b1;
        @(negedge clk); #1;
        chk("to_idle", 32'(slv_req_o), 32'd0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            chk("to_slv_req", 32'(slv_req_o), 32'd1);
            chk("to_rvalid", 32'(mst_rvalid_o), (k == 4) ? 32'd2 : 32'd0);
            chk("to_pulse", 32'(timeout_o), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) chk("to_rdata", mst_rdata_o, 32'hBADC_0FFE);
            tick();
        end
        mst_req_i[1] = 1'b0;
        @(negedge clk); #1;
        chk("to_back_idle", 32'(busy_o), 32'd0);
        tick();

        // Response in the expiry cycle wins over the timeout.
        mst_req_i[1] = 1'b1;
        serve(1, 4, 1'b1, 32'h77);

        // Abort in the second write cycle, late grant in Idle, then master 1 served.
        mst_req_i[0] = 1'b1; mst_wen_i[0] = 1'b0;
        @(negedge clk); #1;
        tick();
        @(negedge clk); #1;
        chk("ab_w1_req", 32'(slv_req_o), 32'd1);
        tick();
        mst_req_i[0] = 1'b0;
        @(negedge clk); #1;
        chk("ab_w2_req", 32'(slv_req_o), 32'd0);
        chk("ab_w2_gnt", 32'(mst_gnt_o), 32'd0);
        tick();
        slv_gnt_i = 1'b1;
        @(negedge clk); #1;
        chk("ab_idle_busy", 32'(busy_o), 32'd0);
        chk("ab_late_gnt", 32'(mst_gnt_o), 32'd0);
        tick();
        slv_gnt_i = 1'b0;
        mst_req_i[1] = 1'b1; mst_wen_i[1] = 1'b0; mst_wdata_i[1] = 32'hCAFE;
        serve(1, 1, 1'b0, 32'h0);

        // Reset in the middle of a master 0 read.
        mst_req_i[0] = 1'b1; mst_wen_i = 2'b11;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mst_req_i = '0;
        @(negedge clk); #1;
        chk("mr_slv_req", 32'(slv_req_o), 32'd0);
        chk("mr_busy", 32'(busy_o), 32'd0);
        chk("mr_slv_wen", 32'(slv_wen_o), 32'd1);
        chk("mr_rvalid", 32'(mst_rvalid_o), 32'd0);
        tick();
        mst_req_i = 2'b11;
        serve(0, 1, 1'b1, 32'h5A5A);
        serve(1, 1, 1'b1, 32'h6B6B);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            for (int m = 0; m < NR; m++) begin
                if (mst_req_i[m]) begin
                    if (m_last_done[m]) begin
                        if ($urandom_range(1, 0) == 0) begin
                            mst_req_i[m] = 1'b0;
                        end else begin
                            mst_wen_i[m]   = 1'($urandom_range(1, 0));
                            mst_addr_i[m]  = 16'($urandom);
                            mst_wdata_i[m] = $urandom;
                        end
                    end else if ($urandom_range(15, 0) == 0) begin
                        mst_req_i[m] = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    mst_req_i[m]   = 1'b1;
                    mst_wen_i[m]   = 1'($urandom_range(1, 0));
                    mst_addr_i[m]  = 16'($urandom);
                    mst_wdata_i[m] = $urandom;
                end
            end
            slv_gnt_i    = ($urandom_range(3, 0) == 0);
            slv_rvalid_i = ($urandom_range(3, 0) == 0);
            slv_rdata_i  = $urandom;
            rst_i        = ($urandom_range(199, 0) == 0);
            tick();
        end

        rst_i = 1'b0;
        mst_req_i = '0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
